// File: rtl/adc_pipe_seq_ctrl_if.sv
// Bus bundle between the ADC conversion sequencer, the system control logic and the encoder/stage array.
// Defining ADC_PIPE_SEQ_CTRL_DROPCNT_EN adds the dropcnt_o drop counter to the bundle.
interface adc_pipe_seq_ctrl_if #(
   parameter int DATA_W = 3,
   parameter int CNT_W  = 8
);
   logic              start_i;
   logic              stop_i;
   logic [CNT_W-1:0]  nsamp_i;
   logic [DATA_W-1:0] d_i;
   logic              phi1_o;
   logic              phi2_o;
   logic              strobe_o;
   logic              busy_o;
   logic              done_o;
   logic              ovf_o;
   logic [DATA_W-1:0] dout_o;
   logic              dout_valid_o;
   logic              dout_ready_i;
`ifdef ADC_PIPE_SEQ_CTRL_DROPCNT_EN
   logic [7:0]        dropcnt_o;

   modport slave (
      input  start_i, stop_i, nsamp_i, d_i, dout_ready_i,
      output phi1_o, phi2_o, strobe_o, busy_o, done_o, ovf_o, dout_o, dout_valid_o, dropcnt_o
   );
   modport master (
      output start_i, stop_i, nsamp_i, d_i, dout_ready_i,
      input  phi1_o, phi2_o, strobe_o, busy_o, done_o, ovf_o, dout_o, dout_valid_o, dropcnt_o
   );
`else
   modport slave (
      input  start_i, stop_i, nsamp_i, d_i, dout_ready_i,
      output phi1_o, phi2_o, strobe_o, busy_o, done_o, ovf_o, dout_o, dout_valid_o
   );
   modport master (
      output start_i, stop_i, nsamp_i, d_i, dout_ready_i,
      input  phi1_o, phi2_o, strobe_o, busy_o, done_o, ovf_o, dout_o, dout_valid_o
   );
`endif
endinterface

// File: rtl/adc_pipe_seq_ctrl.sv
// Conversion sequencer for the pipelined ADC: phi1/phi2/strobe generation, fill discard, burst count, result FIFO.
// Optional ADC_PIPE_SEQ_CTRL_DROPCNT_EN adds a saturating dropped-sample counter (dropcnt_o).
module adc_pipe_seq_ctrl #(
   parameter int DATA_W     = 3,
   parameter int LAT_CONV   = 2,
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clock_i,
   input  logic               reset_i,
   adc_pipe_seq_ctrl_if.slave bus
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FW = (LAT_CONV > 1) ? $clog2(LAT_CONV + 1) : 1;
   localparam logic [FW-1:0]    FILL_LAST = FW'(LAT_CONV - 1);
   localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t            state_q;
   logic [1:0]        ph_q;
   logic [FW-1:0]     fill_q;
   logic [CNT_W-1:0]  n_q;
   logic [CNT_W-1:0]  cap_q;
   logic              stop_q;
   logic              phi1_q;
   logic              phi2_q;
   logic              strobe_q;
   logic              done_q;
   logic              ovf_q;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
`ifdef ADC_PIPE_SEQ_CTRL_DROPCNT_EN
   logic [7:0]        dropcnt_q;
`endif

   logic start_acc;
   logic last_cap;
   logic wr_req;
   logic rd_en;
   logic full;
   logic wr_en;
   logic drop;

   assign start_acc = (state_q == IDLE) && bus.start_i && (bus.nsamp_i != '0);
   assign last_cap  = (state_q == RUN) && (cap_q == n_q - CNT_ONE);
   assign wr_req    = (state_q == RUN) && (ph_q == 2'd3);
   assign rd_en     = (count_q != '0) && bus.dout_ready_i;
   assign full      = (count_q == FULL_CNT);
   // A read on the same edge frees the slot, so a full FIFO still accepts the write.
   assign wr_en     = wr_req && (!full || rd_en);
   assign drop      = wr_req && full && !rd_en;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         ph_q     <= 2'd0;
         fill_q   <= '0;
         n_q      <= '0;
         cap_q    <= '0;
         stop_q   <= 1'b0;
         phi1_q   <= 1'b0;
         phi2_q   <= 1'b0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         phi1_q   <= 1'b0;
         phi2_q   <= 1'b0;
         strobe_q <= 1'b0;
         case (state_q)
            IDLE: begin
               stop_q <= 1'b0;
               if (start_acc) begin
                  n_q     <= bus.nsamp_i;
                  cap_q   <= '0;
                  fill_q  <= '0;
                  ph_q    <= 2'd0;
                  phi1_q  <= 1'b1;
                  state_q <= FILL;
               end else if (bus.start_i) begin
                  done_q <= 1'b1;
               end
            end
            FILL, RUN: begin
               ph_q     <= ph_q + 2'd1;
               phi2_q   <= (ph_q == 2'd1);
               strobe_q <= (ph_q == 2'd2);
               if (bus.stop_i) stop_q <= 1'b1;
               // Period boundary: the ph3 edge decides whether another period starts.
               if (ph_q == 2'd3) begin
                  if (state_q == RUN) cap_q <= cap_q + CNT_ONE;
                  if (stop_q || bus.stop_i || last_cap) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                     stop_q  <= 1'b0;
                  end else begin
                     phi1_q <= 1'b1;
                     if (state_q == FILL) begin
                        fill_q <= fill_q + FW'(1);
                        if (fill_q == FILL_LAST) state_q <= RUN;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
`ifdef ADC_PIPE_SEQ_CTRL_DROPCNT_EN
         dropcnt_q <= 8'd0;
`endif
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
         if (start_acc) begin
            ovf_q <= 1'b0;
         end else if (drop) begin
            ovf_q <= 1'b1;
         end
`ifdef ADC_PIPE_SEQ_CTRL_DROPCNT_EN
         if (start_acc) begin
            dropcnt_q <= 8'd0;
         end else if (drop && (dropcnt_q != 8'hFF)) begin
            dropcnt_q <= dropcnt_q + 8'd1;
         end
`endif
      end
   end

   // Storage carries no reset; the output mux hides stale contents while empty.
   always_ff @(posedge clock_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= bus.d_i;
   end

   assign bus.phi1_o       = phi1_q;
   assign bus.phi2_o       = phi2_q;
   assign bus.strobe_o     = strobe_q;
   assign bus.busy_o       = (state_q != IDLE);
   assign bus.done_o       = done_q;
   assign bus.ovf_o        = ovf_q;
   assign bus.dout_valid_o = (count_q != '0);
   assign bus.dout_o       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
`ifdef ADC_PIPE_SEQ_CTRL_DROPCNT_EN
   assign bus.dropcnt_o    = dropcnt_q;
`endif

endmodule
